// File: rtl/ctrl_fsm_param_if.sv
// Control-unit interface: sequencing inputs from the IR/flags side and the
// enable/select outputs that steer the accumulator datapath.
interface ctrl_fsm_param_if #(
    parameter int OPW  = 6,
    parameter int NREG = 4
);
    localparam int ENW = 8 + NREG;

    logic            start;
    logic [OPW-1:0]  instruction;
    logic            z;
    logic            alu_done;
    logic [2:0]      alu_op;
    logic [ENW-1:0]  write_en;
    logic [ENW-1:0]  inc_en;
    logic [ENW-1:0]  clr_en;
    logic [4:0]      read_en;
    logic            busy;
    logic            end_process;
    logic            illegal_op;

    // Control unit side: consumes opcode/flags, drives datapath enables.
    modport master (
        input  start, instruction, z, alu_done,
        output alu_op, write_en, inc_en, clr_en, read_en,
               busy, end_process, illegal_op
    );

    // Datapath side: supplies opcode/flags, consumes enables.
    modport slave (
        output start, instruction, z, alu_done,
        input  alu_op, write_en, inc_en, clr_en, read_en,
               busy, end_process, illegal_op
    );
endinterface

// File: rtl/ctrl_fsm_param.sv
// Multicycle control unit for the accumulator datapath.
// Sequences fetch/decode/execute and drives one-hot enables plus the bus
// source select. Register-file depth and data-memory read latency are
// parameters; multiply waits on an external ALU handshake.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   S_IDLE     | after reset, waiting for start
//   S_INIT     | clear PC and AR
//   S_FETCH    | IM -> IR
//   S_DECODE   | latch opcode, dispatch or trap
//   S_EXEC_A   | first (usually only) execute cycle
//   S_EXEC_B   | second execute cycle of STAC
//   S_MEM_WAIT | DM read in flight, MEM_LAT cycles
//   S_ALU_WAIT | multiply in flight, until alu_done
//   S_HALT     | program ended or trapped, waiting for start
module ctrl_fsm_param #(
    parameter int OPW     = 6,
    parameter int NREG    = 4,
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    ctrl_fsm_param_if.master bus
);

    localparam int ENW = 8 + NREG;

    // Enable bit positions; bit 0 is never driven.
    localparam int B_PC  = 1;
    localparam int B_AR  = 2;
    localparam int B_IR  = 3;
    localparam int B_AC  = 4;
    localparam int B_R   = 5;
    localparam int B_DM  = 6;
    localparam int B_ALU = 7;
    localparam int B_R0  = 8;

    // Bus source codes.
    localparam logic [4:0] RD_NONE = 5'd0;
    localparam logic [4:0] RD_IR   = 5'd4;
    localparam logic [4:0] RD_AC   = 5'd5;
    localparam logic [4:0] RD_R    = 5'd6;
    localparam logic [4:0] RD_DM   = 5'd12;
    localparam logic [4:0] RD_IM   = 5'd13;

    // ALU operation codes.
    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_MUL  = 3'd3;
    localparam logic [2:0] ALU_LSH  = 3'd4;

    // Opcodes with fixed encodings; register moves are decoded by range.
    localparam logic [OPW-1:0] OP_NOP    = OPW'(0);
    localparam logic [OPW-1:0] OP_LDAC   = OPW'(1);
    localparam logic [OPW-1:0] OP_LDIAC  = OPW'(2);
    localparam logic [OPW-1:0] OP_STAC   = OPW'(3);
    localparam logic [OPW-1:0] OP_MVACR  = OPW'(4);
    localparam logic [OPW-1:0] OP_MVACAR = OPW'(5);
    localparam logic [OPW-1:0] OP_ADD    = OPW'(6);
    localparam logic [OPW-1:0] OP_SUB    = OPW'(7);
    localparam logic [OPW-1:0] OP_MUL    = OPW'(8);
    localparam logic [OPW-1:0] OP_LSHIFT = OPW'(9);
    localparam logic [OPW-1:0] OP_INAC   = OPW'(10);
    localparam logic [OPW-1:0] OP_CLAC   = OPW'(11);
    localparam logic [OPW-1:0] OP_JPNZ   = OPW'(12);
    localparam logic [OPW-1:0] OP_JMPZ   = OPW'(13);
    localparam logic [OPW-1:0] OP_END    = OPW'(14);

    // Wait counter reload: counts down to zero, last read cycle at zero.
    localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXEC_A,
        S_EXEC_B,
        S_MEM_WAIT,
        S_ALU_WAIT,
        S_HALT
    } state_t;

    state_t          state;
    logic [OPW-1:0]  op_q;
    logic [1:0]      wait_cnt;
    logic            ill_q;

    // Opcode legality: fixed ops 0..14, plus register moves for existing Rk.
    function automatic logic op_legal(input logic [OPW-1:0] op);
        int v;
        v = int'(op);
        return (v < 15) ||
               ((v >= 16) && (v < 16 + NREG)) ||
               ((v >= 32) && (v < 32 + NREG));
    endfunction

    // State sequencing, opcode latch, memory wait counter and trap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            wait_cnt <= '0;
            ill_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) state <= S_INIT;
                end
                S_INIT: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    op_q <= bus.instruction;
                    if (!op_legal(bus.instruction)) begin
                        ill_q <= 1'b1;
                        state <= S_HALT;
                    end else if (bus.instruction == OP_MUL) begin
                        state <= S_ALU_WAIT;
                    end else begin
                        state <= S_EXEC_A;
                    end
                end
                S_EXEC_A: begin
                    case (op_q)
                        OP_LDAC, OP_LDIAC: begin
                            wait_cnt <= LAT_LOAD;
                            state    <= S_MEM_WAIT;
                        end
                        OP_STAC: state <= S_EXEC_B;
                        OP_END:  state <= S_HALT;
                        default: state <= S_FETCH;
                    endcase
                end
                S_EXEC_B: begin
                    state <= S_FETCH;
                end
                S_MEM_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_ALU_WAIT: begin
                    if (bus.alu_done) state <= S_FETCH;
                end
                S_HALT: begin
                    if (bus.start) begin
                        ill_q <= 1'b0;
                        state <= S_INIT;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Enable decode from registered state and latched opcode. The jump
    // condition (z) and the multiply completion (alu_done) qualify the
    // current cycle directly, so these are decoded rather than registered.
    always_comb begin
        bus.alu_op   = ALU_NONE;
        bus.read_en  = RD_NONE;
        bus.write_en = '0;
        bus.inc_en   = '0;
        bus.clr_en   = '0;
        case (state)
            S_INIT: begin
                bus.clr_en[B_PC] = 1'b1;
                bus.clr_en[B_AR] = 1'b1;
            end
            S_FETCH: begin
                bus.read_en        = RD_IM;
                bus.write_en[B_IR] = 1'b1;
            end
            S_EXEC_A: begin
                case (op_q)
                    OP_NOP: begin
                        bus.inc_en[B_PC] = 1'b1;
                    end
                    OP_LDAC: begin
                        bus.read_en        = RD_AC;
                        bus.write_en[B_AR] = 1'b1;
                    end
                    OP_LDIAC: begin
                        bus.read_en        = RD_IR;
                        bus.write_en[B_AR] = 1'b1;
                    end
                    OP_STAC: begin
                        bus.read_en = RD_AC;
                    end
                    OP_MVACR: begin
                        bus.read_en        = RD_AC;
                        bus.write_en[B_R]  = 1'b1;
                        bus.inc_en[B_PC]   = 1'b1;
                    end
                    OP_MVACAR: begin
                        bus.read_en        = RD_AC;
                        bus.write_en[B_AR] = 1'b1;
                        bus.inc_en[B_PC]   = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_LSHIFT: begin
                        bus.alu_op          = (op_q == OP_ADD) ? ALU_ADD :
                                              (op_q == OP_SUB) ? ALU_SUB : ALU_LSH;
                        bus.write_en[B_ALU] = 1'b1;
                        bus.inc_en[B_PC]    = 1'b1;
                    end
                    OP_INAC: begin
                        bus.inc_en[B_AC] = 1'b1;
                        bus.inc_en[B_PC] = 1'b1;
                    end
                    OP_CLAC: begin
                        bus.clr_en[B_AC] = 1'b1;
                        bus.inc_en[B_PC] = 1'b1;
                    end
                    OP_JPNZ, OP_JMPZ: begin
                        // Taken jump loads PC from IR and skips the increment.
                        if ((op_q == OP_JPNZ) ? !bus.z : bus.z) begin
                            bus.read_en        = RD_IR;
                            bus.write_en[B_PC] = 1'b1;
                        end else begin
                            bus.inc_en[B_PC] = 1'b1;
                        end
                    end
                    OP_END: begin
                    end
                    default: begin
                        for (int i = 0; i < NREG; i++) begin
                            if (op_q == OPW'(16 + i)) begin
                                bus.read_en           = RD_AC;
                                bus.write_en[B_R0 + i] = 1'b1;
                                bus.inc_en[B_PC]      = 1'b1;
                            end
                            if (op_q == OPW'(32 + i)) begin
                                bus.read_en        = 5'(16 + i);
                                bus.write_en[B_AC] = 1'b1;
                                bus.inc_en[B_PC]   = 1'b1;
                            end
                        end
                    end
                endcase
            end
            S_EXEC_B: begin
                bus.read_en        = RD_AC;
                bus.write_en[B_DM] = 1'b1;
                bus.inc_en[B_PC]   = 1'b1;
            end
            S_MEM_WAIT: begin
                bus.read_en = RD_DM;
                if (wait_cnt == 2'd0) begin
                    bus.write_en[B_AC] = 1'b1;
                    bus.inc_en[B_PC]   = 1'b1;
                end
            end
            S_ALU_WAIT: begin
                bus.alu_op = ALU_MUL;
                if (bus.alu_done) begin
                    bus.write_en[B_ALU] = 1'b1;
                    bus.inc_en[B_PC]    = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Status outputs decoded from the state register and trap flag.
    assign bus.busy        = (state != S_IDLE) && (state != S_HALT);
    assign bus.end_process = (state == S_HALT);
    assign bus.illegal_op  = ill_q;

endmodule

// File: tb/tb_ctrl_fsm_param.sv
// Bench for ctrl_fsm_param: two instances (4 registers / 3-cycle DM latency
// and 8 registers / 1-cycle DM latency) share stimulus. Each instruction is
// expanded into its expected per-cycle output trace from the opcode rules,
// then played against the selected instance cycle by cycle.
module tb_ctrl_fsm_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       z = 1'b0;
    logic       alu_done = 1'b0;
    logic [5:0] instruction = '0;
    bit         use_b = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ctrl_fsm_param_if #(.OPW(6), .NREG(4)) if_a ();
    ctrl_fsm_param_if #(.OPW(6), .NREG(8)) if_b ();

    assign if_a.start       = start;
    assign if_a.instruction = instruction;
    assign if_a.z           = z;
    assign if_a.alu_done    = alu_done;
    assign if_b.start       = start;
    assign if_b.instruction = instruction;
    assign if_b.z           = z;
    assign if_b.alu_done    = alu_done;

    ctrl_fsm_param #(.OPW(6), .NREG(4), .MEM_LAT(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    ctrl_fsm_param #(.OPW(6), .NREG(8), .MEM_LAT(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    // Observed output bundle: {alu_op, read_en, clr, inc, write, busy, end, illegal}
    logic [58:0] obs_a, obs_b;
    assign obs_a = {if_a.alu_op, if_a.read_en, 16'(if_a.clr_en), 16'(if_a.inc_en),
                    16'(if_a.write_en), if_a.busy, if_a.end_process, if_a.illegal_op};
    assign obs_b = {if_b.alu_op, if_b.read_en, 16'(if_b.clr_en), 16'(if_b.inc_en),
                    16'(if_b.write_en), if_b.busy, if_b.end_process, if_b.illegal_op};

    localparam int PC = 1, AR = 2, IR = 3, AC = 4, RR = 5, DM = 6, ALU = 7;

    // Expected trace, one entry per clock cycle.
    logic [58:0] exp_q[$];
    logic [5:0]  ins_q[$];
    bit          z_q[$];
    bit          dn_q[$];
    bit          st_q[$];
    string       tag_q[$];

    bit m_halted = 1'b0;
    bit m_ill    = 1'b0;

    task automatic chk(input string tag, input logic [58:0] got, input logic [58:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] b(input int i);
        return 16'(1) << i;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [58:0] mk(input logic [2:0] alu, input logic [4:0] rd,
                                       input logic [15:0] clr, input logic [15:0] inc,
                                       input logic [15:0] wr, input bit bsy,
                                       input bit endp, input bit ill);
        return {alu, rd, clr, inc, wr, bsy, endp, ill};
    endfunction

    task automatic push(input string t, input logic [58:0] e, input logic [5:0] ins,
                        input bit zz, input bit dn, input bit st);
        tag_q.push_back(t);
        exp_q.push_back(e);
        ins_q.push_back(ins);
        z_q.push_back(zz);
        dn_q.push_back(dn);
        st_q.push_back(st);
    endtask

    task automatic clear_q();
        tag_q.delete();
        exp_q.delete();
        ins_q.delete();
        z_q.delete();
        dn_q.delete();
        st_q.delete();
    endtask

    // From IDLE or HALT: one waiting cycle, one start cycle, then INIT.
    task automatic start_prog();
        if (m_halted) begin
            push("halt_stay",  mk(0, 0, 0, 0, 0, 0, 1, m_ill), '0, rb(), rb(), 1'b0);
            push("halt_start", mk(0, 0, 0, 0, 0, 0, 1, m_ill), '0, rb(), rb(), 1'b1);
        end else begin
            push("idle_stay",  mk(0, 0, 0, 0, 0, 0, 0, 0), '0, rb(), rb(), 1'b0);
            push("idle_start", mk(0, 0, 0, 0, 0, 0, 0, 0), '0, rb(), rb(), 1'b1);
        end
        push("init", mk(0, 0, b(PC) | b(AR), 0, 0, 1, 0, 0), '0, rb(), rb(), rb());
        m_ill    = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic finish_prog();
        m_halted = 1'b1;
        push("halt", mk(0, 0, 0, 0, 0, 0, 1, m_ill), '0, rb(), rb(), 1'b0);
    endtask

    // Expected cycles of one instruction: FETCH, DECODE, then its execute cycles.
    task automatic build_instr(input int op, input bit zz, input int d, input int nr,
                               input int ml, output bit stop);
        logic [5:0]  ins;
        logic [58:0] e;
        string       t;
        bit          lgl;
        bit          tk;
        ins  = 6'(op);
        t    = $sformatf("op%0d", op);
        stop = 1'b0;
        push({t, "_fetch"},  mk(0, 13, 0, 0, b(IR), 1, 0, 0), ins, zz, rb(), rb());
        push({t, "_decode"}, mk(0, 0, 0, 0, 0, 1, 0, 0),      ins, zz, rb(), rb());
        lgl = (op < 15) || (op >= 16 && op < 16 + nr) || (op >= 32 && op < 32 + nr);
        if (!lgl) begin
            stop  = 1'b1;
            m_ill = 1'b1;
            return;
        end
        if (op == 8) begin
            for (int i = 0; i < d; i++)
                push({t, "_alu_wait"}, mk(3, 0, 0, 0, 0, 1, 0, 0), ins, zz, 1'b0, rb());
            push({t, "_alu_done"}, mk(3, 0, 0, b(PC), b(ALU), 1, 0, 0), ins, zz, 1'b1, rb());
            return;
        end
        if (op == 1 || op == 2) begin
            push({t, "_exec"}, mk(0, (op == 1) ? 5'd5 : 5'd4, 0, 0, b(AR), 1, 0, 0),
                 ins, zz, rb(), rb());
            for (int i = 0; i < ml - 1; i++)
                push({t, "_mem_wait"}, mk(0, 12, 0, 0, 0, 1, 0, 0), ins, zz, rb(), rb());
            push({t, "_mem_last"}, mk(0, 12, 0, b(PC), b(AC), 1, 0, 0), ins, zz, rb(), rb());
            return;
        end
        if (op == 3) begin
            push({t, "_exec_a"}, mk(0, 5, 0, 0, 0, 1, 0, 0),          ins, zz, rb(), rb());
            push({t, "_exec_b"}, mk(0, 5, 0, b(PC), b(DM), 1, 0, 0),  ins, zz, rb(), rb());
            return;
        end
        case (op)
            0:  e = mk(0, 0, 0, b(PC), 0, 1, 0, 0);
            4:  e = mk(0, 5, 0, b(PC), b(RR), 1, 0, 0);
            5:  e = mk(0, 5, 0, b(PC), b(AR), 1, 0, 0);
            6:  e = mk(1, 0, 0, b(PC), b(ALU), 1, 0, 0);
            7:  e = mk(2, 0, 0, b(PC), b(ALU), 1, 0, 0);
            9:  e = mk(4, 0, 0, b(PC), b(ALU), 1, 0, 0);
            10: e = mk(0, 0, 0, b(PC) | b(AC), 0, 1, 0, 0);
            11: e = mk(0, 0, b(AC), b(PC), 0, 1, 0, 0);
            12, 13: begin
                tk = (op == 12) ? !zz : zz;
                e  = tk ? mk(0, 4, 0, 0, b(PC), 1, 0, 0) : mk(0, 0, 0, b(PC), 0, 1, 0, 0);
            end
            14: begin
                e    = mk(0, 0, 0, 0, 0, 1, 0, 0);
                stop = 1'b1;
            end
            default: begin
                if (op < 32) e = mk(0, 5, 0, b(PC), b(8 + op - 16), 1, 0, 0);
                else         e = mk(0, 5'(op - 16), 0, b(PC), b(AC), 1, 0, 0);
            end
        endcase
        push({t, "_exec"}, e, ins, zz, rb(), rb());
    endtask

    // Play up to n queued cycles (n < 0: all) against the selected instance.
    task automatic run_q(input bit which, input int n);
        int cnt;
        cnt = 0;
        use_b = which;
        while (exp_q.size() > 0 && (n < 0 || cnt < n)) begin
            @(negedge clk);
            instruction = ins_q.pop_front();
            z           = z_q.pop_front();
            alu_done    = dn_q.pop_front();
            start       = st_q.pop_front();
            #1;
            chk(tag_q.pop_front(), use_b ? obs_b : obs_a, exp_q.pop_front());
            cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        start    = 1'b0;
        alu_done = 1'b0;
        #1;
        chk("reset_a", obs_a, '0);
        chk("reset_b", obs_b, '0);
        @(negedge clk);
        rst_n    = 1'b1;
        m_halted = 1'b0;
        m_ill    = 1'b0;
        clear_q();
    endtask

    function automatic int pick(input int nr);
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 40) return int'($urandom_range(0, 13));
        if (r < 55) return 16 + int'($urandom_range(0, nr - 1));
        if (r < 70) return 32 + int'($urandom_range(0, nr - 1));
        if (r < 80) return 14;
        return int'($urandom_range(0, 63));
    endfunction

    task automatic rand_prog(input bit which, input int nr, input int ml);
        bit stop;
        int n;
        start_prog();
        n    = int'($urandom_range(1, 10));
        stop = 1'b0;
        for (int i = 0; i < n && !stop; i++)
            build_instr(pick(nr), rb(), int'($urandom_range(0, 6)), nr, ml, stop);
        if (!stop) build_instr(14, rb(), 0, nr, ml, stop);
        finish_prog();
        run_q(which, -1);
    endtask

    initial begin
        bit s;

        // Instance A: NREG=4, MEM_LAT=3
        do_reset();
        start_prog();
        build_instr(0, 1'b0, 0, 4, 3, s);
        build_instr(14, 1'b0, 0, 4, 3, s);
        finish_prog();
        run_q(1'b0, -1);

        start_prog();
        build_instr(1, 1'b0, 0, 4, 3, s);
        build_instr(8, 1'b1, 5, 4, 3, s);
        build_instr(12, 1'b0, 0, 4, 3, s);
        build_instr(12, 1'b1, 0, 4, 3, s);
        build_instr(13, 1'b1, 0, 4, 3, s);
        build_instr(13, 1'b0, 0, 4, 3, s);
        build_instr(3, 1'b0, 0, 4, 3, s);
        build_instr(2, 1'b1, 0, 4, 3, s);
        build_instr(10, 1'b0, 0, 4, 3, s);
        build_instr(11, 1'b0, 0, 4, 3, s);
        build_instr(19, 1'b0, 0, 4, 3, s);
        build_instr(35, 1'b0, 0, 4, 3, s);
        build_instr(14, 1'b0, 0, 4, 3, s);
        finish_prog();
        run_q(1'b0, -1);

        start_prog();
        build_instr(20, 1'b0, 0, 4, 3, s);
        finish_prog();
        start_prog();
        build_instr(63, 1'b0, 0, 4, 3, s);
        finish_prog();
        start_prog();
        build_instr(15, 1'b0, 0, 4, 3, s);
        finish_prog();
        run_q(1'b0, -1);

        for (int i = 0; i < 20; i++) rand_prog(1'b0, 4, 3);

        // Instance B: NREG=8, MEM_LAT=1
        do_reset();
        start_prog();
        build_instr(39, 1'b0, 0, 8, 1, s);
        build_instr(20, 1'b0, 0, 8, 1, s);
        build_instr(1, 1'b0, 0, 8, 1, s);
        build_instr(23, 1'b0, 0, 8, 1, s);
        build_instr(14, 1'b0, 0, 8, 1, s);
        finish_prog();
        run_q(1'b1, -1);

        // Reset asserted in the middle of a multiply wait.
        start_prog();
        build_instr(8, 1'b0, 10, 8, 1, s);
        run_q(1'b1, 8);
        clear_q();
        #2;
        rst_n    = 1'b0;
        start    = 1'b0;
        alu_done = 1'b0;
        #1;
        chk("async_reset", obs_b, '0);
        @(negedge clk);
        rst_n    = 1'b1;
        m_halted = 1'b0;
        m_ill    = 1'b0;
        start_prog();
        build_instr(0, 1'b0, 0, 8, 1, s);
        build_instr(14, 1'b0, 0, 8, 1, s);
        finish_prog();
        run_q(1'b1, -1);

        for (int i = 0; i < 20; i++) rand_prog(1'b1, 8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
